// File: rtl/piso_serializer.sv
// Double-buffered parallel-in/serial-out bit source: a holding register refills the
// shift register on the final-bit edge so consecutive words stream without a gap.
module piso_serializer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   output logic                     load_ready,
   input  logic                     enable,
   output logic                     x,
   output logic                     x_valid,
   output logic                     last,
   output logic                     busy,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] r_hr;
   logic             r_hr_full;
   logic [CW-1:0]    r_cnt;

   logic w_accept;
   logic w_final;
   logic w_xfer;
   logic w_shift;

   assign w_accept = load_valid && !r_hr_full && !clear;
   assign w_final  = (r_state == SHIFT) && enable && (r_cnt == LAST_IDX);
   assign w_xfer   = r_hr_full && ((r_state == IDLE) || w_final);
   // The final-bit shift toward IDLE empties SR, which keeps x at 0 while idle.
   assign w_shift  = (r_state == SHIFT) && enable && !w_xfer;

   // State register.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_hr_full) begin
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (w_final && !r_hr_full) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding register, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_sr      <= '0;
         r_hr      <= '0;
         r_hr_full <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_xfer) begin
            r_sr      <= r_hr;
            r_hr_full <= 1'b0;
            r_cnt     <= '0;
         end else if (w_shift) begin
            if (MSB_FIRST) begin
               r_sr <= {r_sr[WIDTH-2:0], 1'b0};
            end else begin
               r_sr <= {1'b0, r_sr[WIDTH-1:1]};
            end
            if (w_final) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_sr  <= r_sr;
            r_cnt <= r_cnt;
         end
         if (w_accept) begin
            r_hr      <= load_data;
            r_hr_full <= 1'b1;
         end else begin
            r_hr <= r_hr;
         end
      end
   end

   // Output decode from registered state only (load_ready also sees clear).
   always_comb begin
      x_valid    = (r_state == SHIFT);
      last       = (r_state == SHIFT) && (r_cnt == LAST_IDX);
      busy       = (r_state == SHIFT) || r_hr_full;
      bit_idx    = r_cnt;
      x          = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
      load_ready = !r_hr_full && !clear;
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a queue/index reference model checked every
// cycle, directed stream scenarios with literal expectations, then randomized traffic.
module tb_piso_serializer;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         clear, load_valid, enable;
   logic [W-1:0] load_data;
   logic         load_ready, x, x_valid, last, busy;
   logic [4:0]   bit_idx;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
      .clk(clk), .clear(clear), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .enable(enable), .x(x), .x_valid(x_valid),
      .last(last), .busy(busy), .bit_idx(bit_idx)
   );

   logic       s_clear, s_valid, s_enable;
   logic [3:0] s_data;
   logic       s_ready, s_x, s_x_valid, s_last, s_busy;
   logic [1:0] s_bit_idx;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .clear(s_clear), .load_valid(s_valid), .load_data(s_data),
      .load_ready(s_ready), .enable(s_enable), .x(s_x), .x_valid(s_x_valid),
      .last(s_last), .busy(s_busy), .bit_idx(s_bit_idx)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a one-deep pending-word queue plus the word on the line and its bit index.
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_word;
   int           m_k;
   bit           m_valid, m_started, m_accepted, m_acc;

   initial begin
      m_valid = 0; m_k = 0; m_started = 0; m_accepted = 0; m_word = '0;
      forever begin
         @(posedge clk);
         m_started  = 1;
         m_accepted = 0;
         if (clear) begin
            m_valid = 0; m_k = 0; m_q.delete();
         end else begin
            m_acc = load_valid && (m_q.size() == 0);
            if (m_valid && enable) begin
               if (m_k == W - 1) begin
                  m_k = 0;
                  if (m_q.size() != 0) m_word = m_q.pop_front();
                  else m_valid = 0;
               end else begin
                  m_k++;
               end
            end else if (!m_valid && m_q.size() != 0) begin
               m_word = m_q.pop_front(); m_k = 0; m_valid = 1;
            end
            if (m_acc) m_q.push_back(load_data);
            m_accepted = m_acc;
         end
      end
   end

   // Every-cycle comparison of the main instance against the model.
   initial forever begin
      @(negedge clk);
      if (m_started) begin
         check("x_valid", x_valid, m_valid);
         check("x", x, m_valid ? m_word[W-1-m_k] : 1'b0);
         check("last", last, m_valid && (m_k == W - 1));
         check("busy", busy, m_valid || (m_q.size() != 0));
         check("load_ready", load_ready, (m_q.size() == 0) && !clear);
         if (m_valid) check("bit_idx", bit_idx, m_k);
      end
   end

   // Capture of consumed bits and x_valid shape for the directed scenarios.
   logic [63:0] cap;
   int          cap_n, vcyc, vrise, last_at;
   bit          cap_en = 0, prev_v = 0;

   initial forever begin
      @(negedge clk);
      if (cap_en) begin
         if (x_valid) vcyc++;
         if (x_valid && !prev_v) vrise++;
         prev_v = x_valid;
         if (x_valid && enable) begin
            if (last) last_at = cap_n;
            cap = {cap[62:0], x};
            cap_n++;
         end
      end
   end

   task automatic cap_start();
      cap = '0; cap_n = 0; vcyc = 0; vrise = 0; last_at = -1; prev_v = 0; cap_en = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_accepted) break;
      end
      check("accepted", m_accepted, 1'b1);
      load_valid = 1'b0;
   endtask

   task automatic wait_idx(input int idx, input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 60; i++) begin
         if (x_valid && bit_idx == 5'(idx)) begin
            found = 1;
            break;
         end
         tick();
      end
      check(name, found, 1'b1);
   endtask

   logic [3:0] seq4;
   int         n4, last4, lidx4;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clear = 1'b1; load_valid = 1'b0; load_data = '0; enable = 1'b1;
      s_clear = 1'b1; s_valid = 1'b0; s_data = 4'b0000; s_enable = 1'b1;
      tick(); tick();
      check("rst_x_valid", x_valid, 1'b0);
      check("rst_x", x, 1'b0);
      check("rst_last", last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_bit_idx", bit_idx, 5'd0);
      check("rst_ready_in_clear", load_ready, 1'b0);
      clear = 1'b0; s_clear = 1'b0;
      #1;
      check("rst_ready_after", load_ready, 1'b1);

      // Single word with latency pins
      cap_start();
      send(32'hCD4C9ACA);
      check("lat_e0_valid", x_valid, 1'b0);
      check("lat_e0_busy", busy, 1'b1);
      tick();
      check("lat_e1_valid", x_valid, 1'b1);
      check("lat_e1_x", x, 1'b1);
      repeat (40) tick();
      cap_en = 0;
      check("single_bits", cap[31:0], 32'hCD4C9ACA);
      check("single_count", cap_n, 32);
      check("single_vcyc", vcyc, 32);
      check("single_last", last_at, 31);

      // Back-to-back words stream gapless
      cap_start();
      send(32'hCD4C9ACA);
      send(32'hA5A5A5A5);
      repeat (70) tick();
      cap_en = 0;
      check("b2b_bits", cap, 64'hCD4C9ACAA5A5A5A5);
      check("b2b_count", cap_n, 64);
      check("b2b_vcyc", vcyc, 64);
      check("b2b_rises", vrise, 1);

      // Stall three cycles at bit 5
      cap_start();
      send(32'hCD4C9ACA);
      wait_idx(5, "stall_reach");
      enable = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      repeat (40) tick();
      cap_en = 0;
      check("stall_bits", cap[31:0], 32'hCD4C9ACA);
      check("stall_vcyc", vcyc, 35);
      check("stall_last", last_at, 31);

      // Clear mid-stream with the holding register full
      send(32'hCD4C9ACA);
      send(32'hA5A5A5A5);
      wait_idx(10, "midrst_reach");
      check("midrst_busy", busy, 1'b1);
      check("midrst_ready", load_ready, 1'b0);
      clear = 1'b1;
      tick();
      check("midrst_valid", x_valid, 1'b0);
      check("midrst_busy0", busy, 1'b0);
      tick();
      clear = 1'b0;
      #1;
      check("midrst_ready1", load_ready, 1'b1);
      cap_start();
      send(32'h12345678);
      repeat (40) tick();
      cap_en = 0;
      check("reload_bits", cap[31:0], 32'h12345678);
      check("reload_count", cap_n, 32);

      // LSB-first 4-bit instance
      s_valid = 1'b1; s_data = 4'b1101;
      tick();
      s_valid = 1'b0;
      seq4 = 4'b0000; n4 = 0; last4 = -1; lidx4 = -1;
      for (int i = 0; i < 8; i++) begin
         if (s_x_valid) begin
            if (s_last) begin
               last4 = n4;
               lidx4 = int'(s_bit_idx);
            end
            seq4 = {seq4[2:0], s_x};
            n4++;
         end
         tick();
      end
      check("lsb_seq", seq4, 4'b1011);
      check("lsb_count", n4, 4);
      check("lsb_last", last4, 3);
      check("lsb_last_idx", lidx4, 3);
      check("lsb_busy_end", s_busy, 1'b0);
      check("lsb_ready_end", s_ready, 1'b1);

      // Randomized traffic with enables, stalls and occasional clears
      for (int c = 0; c < 3000; c++) begin
         tick();
         clear  = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 9) != 0);
         if (m_accepted || !load_valid) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = $urandom;
         end
      end
      clear = 1'b0; enable = 1'b1; load_valid = 1'b0;
      repeat (80) tick();
      check("drain_idle", x_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
